stq_drain_ctrl: RTL and testbench

- Read-side controller for the partitioned store-queue RAM.
- Tracks committed stores and reads them from the RAM in program order, starting at the drain head.
- Presents each store to the data cache on a valid/ready request channel.
- Sits between the LSQ commit logic and the D-cache store port. Handles partition-resized wrap-around and waits for the RAM-ready indication.

---
 rtl/stq_drain_ctrl.sv | 164 ++++++++++++++++
 tb/tb_stq_drain_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stq_drain_ctrl.sv
// Drains committed stores from the partitioned STQ RAM to the D-cache in program order.
// Commit->valid in 2 cycles, one store per 2 cycles; a raised request holds until the cache accepts it.
module stq_drain_ctrl #(
  parameter int DEPTH         = 32,
  parameter int INDEX         = 5,
  parameter int WIDTH         = 64,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 commit_i,
  input  logic [NUM_PARTS-1:0] lsqPartitionActive_i,
  input  logic                 stqRamReady_i,
  output logic [INDEX-1:0]     rdAddr_o,
  input  logic [WIDTH-1:0]     rdData_i,
  output logic                 cacheReqValid_o,
  output logic [WIDTH-1:0]     cacheReqData_o,
  output logic [INDEX-1:0]     cacheReqIdx_o,
  input  logic                 cacheReqReady_i,
  output logic [INDEX:0]       pendingCnt_o,
  output logic                 drainIdle_o,
  output logic                 overflow_o
);

  localparam int PART_DEPTH = DEPTH / NUM_PARTS;
  localparam logic [INDEX:0] ONE_W = (INDEX+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_REQ  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [INDEX-1:0]     head_q, head_d;
  logic [INDEX:0]       pending_q, pending_d;
  logic [NUM_PARTS-1:0] mask_q, mask_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [INDEX-1:0]     idx_q, idx_d;
  logic                 ovf_q, ovf_d;

  logic [NUM_PARTS_LOG:0] active_parts;
  logic [INDEX:0]         eff_depth;
  logic [INDEX:0]         head_inc;
  logic [INDEX-1:0]       head_wrap;
  logic                   fire;
  logic                   frozen;
  logic                   full;

  always_comb begin
    active_parts = '0;
    for (int i = 0; i < NUM_PARTS; i++) begin
      active_parts = active_parts + (NUM_PARTS_LOG+1)'(mask_q[i]);
    end
  end

  assign eff_depth = (INDEX+1)'(active_parts) * (INDEX+1)'(PART_DEPTH);
  assign head_inc  = {1'b0, head_q} + ONE_W;
  assign head_wrap = (head_inc == eff_depth) ? '0 : head_inc[INDEX-1:0];
  assign fire      = valid_q & cacheReqReady_i;
  assign full      = (pending_q == eff_depth);

  // A mask that differs from the one captured while empty stalls all new reads.
  assign frozen    = (lsqPartitionActive_i != mask_q) && (pending_q != '0);
  assign mask_d    = (pending_q == '0) ? lsqPartitionActive_i : mask_q;

  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (commit_i && !fire) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + ONE_W;
      end
    end else if (!commit_i && fire) begin
      pending_d = pending_q - ONE_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!frozen && stqRamReady_i && (pending_d != '0)) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!frozen && stqRamReady_i) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (fire) begin
          state_d = (!frozen && stqRamReady_i && (pending_d != '0)) ? ST_READ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      ST_READ: begin
        if (!frozen && stqRamReady_i) begin
          valid_d = 1'b1;
          data_d  = rdData_i;
          idx_d   = head_q;
        end
      end
      ST_REQ: begin
        if (fire) begin
          valid_d = 1'b0;
          head_d  = head_wrap;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      valid_q   <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rdAddr_o        = head_q;
  assign cacheReqValid_o = valid_q;
  assign cacheReqData_o  = data_q;
  assign cacheReqIdx_o   = idx_q;
  assign pendingCnt_o    = pending_q;
  assign overflow_o      = ovf_q;
  assign drainIdle_o     = (state_q == ST_IDLE) && (pending_q == '0);

endmodule

// File: tb/tb_stq_drain_ctrl.sv
// Bench for stq_drain_ctrl: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a transaction-level drain model.
module tb_stq_drain_ctrl;

  logic        clk;
  logic        reset;
  logic        commit_i;
  logic [3:0]  mask;
  logic        ram_rdy;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        req_vld;
  logic [63:0] req_dat;
  logic [4:0]  req_idx;
  logic        req_rdy;
  logic [5:0]  pend_cnt;
  logic        drain_idle;
  logic        ovf;

  logic [63:0] mem [32];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fired[$];
  int fire_cyc[$];

  assign rd_data = mem[rd_addr];

  stq_drain_ctrl #(.DEPTH(32), .INDEX(5), .WIDTH(64), .NUM_PARTS(4), .NUM_PARTS_LOG(2)) dut (
    .clk                  (clk),
    .reset                (reset),
    .commit_i             (commit_i),
    .lsqPartitionActive_i (mask),
    .stqRamReady_i        (ram_rdy),
    .rdAddr_o             (rd_addr),
    .rdData_i             (rd_data),
    .cacheReqValid_o      (req_vld),
    .cacheReqData_o       (req_dat),
    .cacheReqIdx_o        (req_idx),
    .cacheReqReady_i      (req_rdy),
    .pendingCnt_o         (pend_cnt),
    .drainIdle_o          (drain_idle),
    .overflow_o           (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // Transaction view: a drain is "launched" once the RAM may be read, becomes a request
  // one usable RAM cycle later, and the request retires on the cache handshake.
  int       m_head = 0;
  int       m_pend = 0;
  bit       m_req = 0;
  bit       m_launched = 0;
  bit       m_ovf = 0;
  bit [3:0] m_mask = 4'hF;
  logic [63:0] m_data = '0;
  int       m_idx = 0;

  task automatic model_step();
    bit frozen;
    bit fire;
    int eff;
    int new_pend;
    int nh;
    frozen   = (mask != m_mask) && (m_pend != 0);
    eff      = $countones(m_mask) * 8;
    fire     = m_req && req_rdy;
    new_pend = m_pend;
    if (commit_i && !fire) begin
      if (m_pend == eff) m_ovf = 1;
      else new_pend = m_pend + 1;
    end else if (!commit_i && fire) begin
      new_pend = m_pend - 1;
    end
    if (m_req) begin
      if (fire) begin
        m_req = 0;
        nh = m_head + 1;
        m_head = (nh == eff) ? 0 : (nh % 32);
        m_launched = !frozen && ram_rdy && (new_pend > 0);
      end
    end else if (m_launched) begin
      if (!frozen && ram_rdy) begin
        m_req = 1;
        m_data = mem[m_head];
        m_idx = m_head;
        m_launched = 0;
      end
    end else if (!frozen && ram_rdy && (new_pend > 0)) begin
      m_launched = 1;
    end
    if (m_pend == 0) m_mask = mask;
    m_pend = new_pend;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_head = 0; m_pend = 0; m_req = 0; m_launched = 0; m_ovf = 0;
      m_mask = 4'hF; m_data = '0; m_idx = 0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("valid", req_vld, m_req);
    chk("pending", pend_cnt, m_pend);
    chk("idle", drain_idle, (m_pend == 0) && !m_req && !m_launched);
    chk("overflow", ovf, m_ovf);
    chk("rdaddr", rd_addr, m_head);
    if (m_req) begin
      chk("data", req_dat, m_data);
      chk("idx", req_idx, m_idx);
    end
  end

  always @(negedge clk) begin
    if (reset && req_vld && req_rdy) begin
      fired.push_back(int'(req_idx));
      fire_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    commit_i = 1'b0;
    req_rdy = 1'b0;
    #1;
    chk("rst_valid", req_vld, 0);
    chk("rst_data", req_dat, 0);
    chk("rst_idx", req_idx, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_idle", drain_idle, 1);
    chk("rst_ovf", ovf, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (!drain_idle && k < max_cyc) begin
      tick();
      k++;
    end
    chk("wait_idle_bound", drain_idle, 1);
  endtask

  task automatic run_wrap(input logic [3:0] m, input int exp_after15);
    do_reset();
    mask = m; ram_rdy = 1'b1; req_rdy = 1'b1;
    tick();
    fired.delete();
    commit_i = 1'b1;
    repeat (17) tick();
    commit_i = 1'b0;
    wait_idle(200);
    chk("wrap_count", fired.size(), 17);
    if (fired.size() == 17) begin
      chk("wrap_idx15", fired[15], 15);
      chk("wrap_next", fired[16], exp_after15);
    end
    req_rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b0; commit_i = 1'b0; mask = 4'hF; ram_rdy = 1'b1; req_rdy = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'hA5A5;

    // 1: single store, commit->READ->valid latency
    do_reset();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    chk("t1_valid_n1", req_vld, 0);
    chk("t1_pend_n1", pend_cnt, 1);
    chk("t1_idle_n1", drain_idle, 0);
    tick();
    chk("t1_valid_n2", req_vld, 1);
    chk("t1_data", req_dat, 64'hA5A5);
    chk("t1_model_data", m_data, 64'hA5A5);
    chk("t1_idx", req_idx, 0);
    req_rdy = 1'b1;
    tick();
    req_rdy = 1'b0;
    chk("t1_pend_done", pend_cnt, 0);
    chk("t1_idle_done", drain_idle, 1);
    chk("t1_model_pend", m_pend, 0);

    // 2: backpressure holds the request stable, then drains 0,1,2 every other cycle
    do_reset();
    commit_i = 1'b1;
    repeat (3) tick();
    commit_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", req_vld, 1);
      chk("t2_hold_idx", req_idx, 0);
      chk("t2_hold_data", req_dat, mem[0]);
      chk("t2_hold_pend", pend_cnt, 3);
      tick();
    end
    fired.delete(); fire_cyc.delete();
    req_rdy = 1'b1;
    wait_idle(20);
    req_rdy = 1'b0;
    chk("t2_fires", fired.size(), 3);
    if (fired.size() == 3) begin
      chk("t2_idx0", fired[0], 0);
      chk("t2_idx1", fired[1], 1);
      chk("t2_idx2", fired[2], 2);
      chk("t2_gap1", fire_cyc[1] - fire_cyc[0], 2);
      chk("t2_gap2", fire_cyc[2] - fire_cyc[1], 2);
    end

    // 3: wrap at effective depth
    run_wrap(4'b0011, 0);
    run_wrap(4'b1111, 16);

    // 4: simultaneous commit and fire keeps the count
    do_reset();
    commit_i = 1'b1;
    repeat (2) tick();
    chk("t4_valid", req_vld, 1);
    chk("t4_pend_before", pend_cnt, 2);
    req_rdy = 1'b1;
    tick();
    commit_i = 1'b0;
    chk("t4_pend_after", pend_cnt, 2);
    chk("t4_model_pend", m_pend, 2);
    wait_idle(40);
    req_rdy = 1'b0;

    // 5: RAM not ready holds off the request
    do_reset();
    req_rdy = 1'b1;
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    ram_rdy = 1'b0;
    repeat (3) begin
      tick();
      chk("t5_no_valid", req_vld, 0);
      chk("t5_pend", pend_cnt, 1);
    end
    ram_rdy = 1'b1;
    req_rdy = 1'b0;
    tick();
    chk("t5_valid_late", req_vld, 1);
    req_rdy = 1'b1;
    wait_idle(20);
    req_rdy = 1'b0;

    // 6: overflow is sticky; a changed mask freezes the drain until restored
    do_reset();
    mask = 4'b0001; ram_rdy = 1'b0;
    tick();
    commit_i = 1'b1;
    repeat (8) tick();
    chk("t6_full_pend", pend_cnt, 8);
    chk("t6_no_ovf", ovf, 0);
    tick();
    commit_i = 1'b0;
    chk("t6_ovf", ovf, 1);
    chk("t6_pend_held", pend_cnt, 8);
    chk("t6_model_ovf", m_ovf, 1);
    mask = 4'b0011; ram_rdy = 1'b1;
    repeat (4) begin
      tick();
      chk("t6_frozen_valid", req_vld, 0);
    end
    mask = 4'b0001;
    repeat (2) tick();
    chk("t6_thaw_valid", req_vld, 1);
    chk("t6_thaw_idx", req_idx, 0);
    req_rdy = 1'b1;
    wait_idle(40);
    req_rdy = 1'b0;
    chk("t6_ovf_sticky", ovf, 1);

    // 7: reset during a request drops valid at once
    do_reset();
    mask = 4'hF;
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    tick();
    chk("t7_valid_pre", req_vld, 1);
    #1 reset = 1'b0;
    #1;
    chk("t7_valid_async", req_vld, 0);
    chk("t7_pend_async", pend_cnt, 0);
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      commit_i = ($urandom_range(0, 99) < 40);
      ram_rdy  = ($urandom_range(0, 99) < 80);
      req_rdy  = ($urandom_range(0, 99) < 60);
      if (m_pend == 0 && !m_req && !m_launched && $urandom_range(0, 99) < 10) begin
        int k;
        k = $urandom_range(1, 4);
        if (k * 8 > m_head) mask = 4'((1 << k) - 1);
      end
      tick();
    end
    commit_i = 1'b0; ram_rdy = 1'b1; req_rdy = 1'b1;
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
